// File: rtl/sub_seq_if.sv
// Start/done handshake bundle for the multi-cycle subtractor: request,
// operands, status and registered results.
interface sub_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] input1;
    logic [WIDTH-1:0] input2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_from_diff;
    logic             zero;
    logic             overflow;

    modport master (
        output start, input1, input2,
        input  busy, done, diff, borrow_from_diff, zero, overflow
    );

    modport slave (
        input  start, input1, input2,
        output busy, done, diff, borrow_from_diff, zero, overflow
    );
endinterface

// File: rtl/sub_seq.sv
// Multi-cycle subtractor: input1 - input2 one CHUNK-bit digit per cycle,
// LSB first, with the borrow rippled between cycles through a register.
module sub_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic     clk,
    input  logic     rst,
    sub_seq_if.slave bus
);
    localparam int N   = WIDTH / CHUNK;
    localparam int K_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Top bit of the result is the borrow out of this digit.
    function automatic logic [CHUNK:0] chunk_sub(
        input logic [CHUNK-1:0] x,
        input logic [CHUNK-1:0] y,
        input logic             bin
    );
        chunk_sub = {1'b0, x} - {1'b0, y} - {{CHUNK{1'b0}}, bin};
    endfunction

    state_t           state_r;
    state_t           state_s;
    logic [K_W-1:0]   k_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] res_r;
    logic             bor_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] diff_r;
    logic             borrow_r;
    logic             zero_r;
    logic             overflow_r;

    logic             accept_s;
    logic             last_s;
    logic [CHUNK:0]   sub_s;
    logic [WIDTH-1:0] diff_next_s;

    // Next-state decode; start is only honoured in IDLE or DONE.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    accept_s = 1'b1;
                    state_s  = RUN;
                end else begin
                    state_s  = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (bus.start) begin
                    accept_s = 1'b1;
                    state_s  = RUN;
                end else begin
                    state_s  = IDLE;
                end
            end
            default: begin
                state_s  = IDLE;
                accept_s = 1'b0;
            end
        endcase
    end

    // Current digit subtraction, merged into the partial result.
    always_comb begin
        last_s      = (k_r == K_W'(N - 1));
        sub_s       = chunk_sub(a_r[int'(k_r) * CHUNK +: CHUNK],
                                b_r[int'(k_r) * CHUNK +: CHUNK],
                                bor_r);
        diff_next_s = res_r;
        diff_next_s[int'(k_r) * CHUNK +: CHUNK] = sub_s[CHUNK-1:0];
    end

    // State, datapath and result registers; results move only on completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            k_r        <= {K_W{1'b0}};
            a_r        <= {WIDTH{1'b0}};
            b_r        <= {WIDTH{1'b0}};
            res_r      <= {WIDTH{1'b0}};
            bor_r      <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            diff_r     <= {WIDTH{1'b0}};
            borrow_r   <= 1'b0;
            zero_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == RUN);
            done_r  <= (state_r == RUN) && last_s;
            if (accept_s) begin
                a_r   <= bus.input1;
                b_r   <= bus.input2;
                k_r   <= {K_W{1'b0}};
                bor_r <= 1'b0;
                res_r <= {WIDTH{1'b0}};
            end else if (state_r == RUN) begin
                res_r <= diff_next_s;
                bor_r <= sub_s[CHUNK];
                k_r   <= k_r + K_W'(1);
                if (last_s) begin
                    diff_r     <= diff_next_s;
                    borrow_r   <= sub_s[CHUNK];
                    zero_r     <= (diff_next_s == {WIDTH{1'b0}});
                    overflow_r <= (a_r[WIDTH-1] != b_r[WIDTH-1]) &&
                                  (diff_next_s[WIDTH-1] != a_r[WIDTH-1]);
                end else begin
                    diff_r     <= diff_r;
                end
            end else begin
                res_r <= res_r;
            end
        end
    end

    assign bus.busy             = busy_r;
    assign bus.done             = done_r;
    assign bus.diff             = diff_r;
    assign bus.borrow_from_diff = borrow_r;
    assign bus.zero             = zero_r;
    assign bus.overflow         = overflow_r;
endmodule

// File: tb/tb_sub_seq.sv
// Self-checking bench for sub_seq: expected results queued at request time,
// popped and compared when done appears.
module tb_sub_seq;
    typedef struct {
        logic [31:0] d;
        logic        bor;
        logic        z;
        logic        ov;
    } exp_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    exp_t sb[$];

    sub_seq_if #(.WIDTH(32)) bus ();

    sub_seq #(.WIDTH(32), .CHUNK(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [32:0] w;
        w     = {1'b0, a} - {1'b0, b};
        e.d   = w[31:0];
        e.bor = w[32];
        e.z   = (w[31:0] == 32'd0);
        e.ov  = (a[31] != b[31]) && (w[31] != a[31]);
        return e;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.input1 = 32'd0;
        bus.input2 = 32'd0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.borrow_from_diff, bus.zero, bus.overflow} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {bus.busy, bus.done, bus.borrow_from_diff, bus.zero, bus.overflow});
        end
        checks++;
        if (bus.diff !== 32'd0) begin
            errors++;
            $display("FAIL reset_diff: got %h expected 00000000", bus.diff);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.diff} !== 34'd0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b done=%b diff=%h expected all zero",
                     bus.busy, bus.done, bus.diff);
        end
    endtask

    task automatic test_arith(input logic [31:0] a, input logic [31:0] b, input string name);
        exp_t e;
        int   cyc;
        int   busy_cnt;
        sb.push_back(model(a, b));
        @(negedge clk);
        bus.input1 = a;
        bus.input2 = b;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.input1 = $urandom;
        bus.input2 = $urandom;
        cyc = 1;
        busy_cnt = 0;
        while (cyc <= 20 && !bus.done) begin
            if (bus.busy) busy_cnt++;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!bus.done) begin
            errors++;
            $display("FAIL %s_timeout: no done within 20 cycles", name);
            void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            checks++;
            if (cyc - 1 !== 4) begin
                errors++;
                $display("FAIL %s_latency: got %0d expected 4", name, cyc - 1);
            end
            checks++;
            if (busy_cnt !== 4 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL %s_busy: busy cycles %0d busy_at_done %b expected 4 and 0",
                         name, busy_cnt, bus.busy);
            end
            checks++;
            if (bus.diff !== e.d) begin
                errors++;
                $display("FAIL %s_diff: got %h expected %h", name, bus.diff, e.d);
            end
            checks++;
            if ({bus.borrow_from_diff, bus.zero, bus.overflow} !== {e.bor, e.z, e.ov}) begin
                errors++;
                $display("FAIL %s_flags: got b/z/o=%b expected %b", name,
                         {bus.borrow_from_diff, bus.zero, bus.overflow}, {e.bor, e.z, e.ov});
            end
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0 || bus.diff !== e.d) begin
                errors++;
                $display("FAIL %s_hold: done=%b diff=%h expected done=0 diff=%h",
                         name, bus.done, bus.diff, e.d);
            end
        end
    endtask

    task automatic test_start_during_run();
        exp_t e;
        int   dones;
        dones = 0;
        sb.push_back(model(32'h0000_1234, 32'h0000_0235));
        @(negedge clk);
        bus.input1 = 32'h0000_1234;
        bus.input2 = 32'h0000_0235;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.input1 = 32'hFFFF_0000;
        bus.input2 = 32'h0000_0001;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (bus.done) begin
                dones++;
                if (dones == 1) begin
                    e = sb.pop_front();
                    checks++;
                    if (bus.diff !== e.d || bus.borrow_from_diff !== e.bor) begin
                        errors++;
                        $display("FAIL ignore_start_result: got %h/%b expected %h/%b",
                                 bus.diff, bus.borrow_from_diff, e.d, e.bor);
                    end
                end
            end
            @(negedge clk);
        end
        checks++;
        if (dones !== 1) begin
            errors++;
            $display("FAIL ignore_start_dones: got %0d expected 1", dones);
            if (dones == 0) void'(sb.pop_front());
        end
    endtask

    task automatic test_reset_mid_run();
        int dones;
        dones = 0;
        @(negedge clk);
        bus.input1 = 32'h1234_5678;
        bus.input2 = 32'h0000_0001;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.borrow_from_diff, bus.zero, bus.overflow} !== 5'b00000
            || bus.diff !== 32'd0) begin
            errors++;
            $display("FAIL midrun_reset_clear: flags %b diff %h expected 00000 00000000",
                     {bus.busy, bus.done, bus.borrow_from_diff, bus.zero, bus.overflow}, bus.diff);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL midrun_reset_no_done: got %0d active cycles expected 0", dones);
        end
        test_arith(32'd45, 32'd42, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [31:0] ops_a[3];
        logic [31:0] ops_b[3];
        exp_t        e;
        int          nxt;
        int          dones;
        ops_a = '{32'h0000_0010, 32'h8000_0000, 32'h0000_0000};
        ops_b = '{32'h0000_0020, 32'h0000_0001, 32'h0000_0000};
        dones = 0;
        @(negedge clk);
        bus.input1 = ops_a[0];
        bus.input2 = ops_b[0];
        bus.start  = 1'b1;
        sb.push_back(model(ops_a[0], ops_b[0]));
        nxt = 1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (bus.done) begin
                dones++;
                checks++;
                if (c % 5 != 0) begin
                    errors++;
                    $display("FAIL b2b_spacing: done at cycle %0d expected multiple of 5", c);
                end
                e = sb.pop_front();
                checks++;
                if (bus.diff !== e.d || {bus.borrow_from_diff, bus.zero, bus.overflow} !== {e.bor, e.z, e.ov}) begin
                    errors++;
                    $display("FAIL b2b_result: got %h/%b expected %h/%b", bus.diff,
                             {bus.borrow_from_diff, bus.zero, bus.overflow}, e.d, {e.bor, e.z, e.ov});
                end
            end
            if (c % 5 == 0) begin
                if (nxt < 3) begin
                    bus.input1 = ops_a[nxt];
                    bus.input2 = ops_b[nxt];
                    sb.push_back(model(ops_a[nxt], ops_b[nxt]));
                    nxt++;
                end else begin
                    bus.start = 1'b0;
                end
            end
        end
        bus.start = 1'b0;
        checks++;
        if (dones !== 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d expected 3", dones);
        end
        sb.delete();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_arith(32'd32, 32'd32, "equal");
        test_arith(32'd45, 32'd42, "small_pos");
        test_arith(32'd42, 32'd45, "small_neg");
        test_arith(32'h0000_0100, 32'h0000_0001, "borrow_chunk1");
        test_arith(32'h0100_0000, 32'h0000_0001, "borrow_chunk3");
        test_arith(32'h8000_0000, 32'h0000_0001, "ovf_neg_pos");
        test_arith(32'h7FFF_FFFF, 32'hFFFF_FFFF, "ovf_pos_neg");
        test_start_during_run();
        test_arith(32'd42, 32'd45, "pre_abort");
        test_reset_mid_run();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
